// File: rtl/wb_regfile.sv
// Writeback-stage register file with write-first bypass,
// retired-instruction counter and a registered commit trace.
module wb_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_wb_i,
   input  logic        instr_valid_wb_i,
   input  logic        rf_we_wb_i,
   input  logic [4:0]  wr_wb_i,
   input  logic [31:0] wd_wb_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   output logic [63:0] instret_o,
   output logic        commit_valid_o,
   output logic [31:0] commit_pc_o,
   output logic [4:0]  commit_rd_o,
   output logic        commit_we_o,
   output logic [31:0] commit_wd_o
);

   logic [31:0] r_regs [32];
   logic [63:0] r_instret;
   logic        r_cvalid;
   logic [31:0] r_cpc;
   logic [4:0]  r_crd;
   logic        r_cwe;
   logic [31:0] r_cwd;
   logic        w_wen;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;

   assign w_wen = instr_valid_wb_i & rf_we_wb_i & (wr_wb_i != 5'd0);

   // Entry 0 is never written; x0 reads are forced to zero below.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wen) begin
         r_regs[wr_wb_i] <= wd_wb_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instret <= '0;
         r_cvalid  <= 1'b0;
         r_cpc     <= '0;
         r_crd     <= '0;
         r_cwe     <= 1'b0;
         r_cwd     <= '0;
      end else begin
         if (instr_valid_wb_i) begin
            r_instret <= r_instret + 64'd1;
         end
         r_cvalid <= instr_valid_wb_i;
         r_cpc    <= pc_wb_i;
         r_crd    <= wr_wb_i;
         r_cwe    <= w_wen;
         r_cwd    <= w_wen ? wd_wb_i : 32'd0;
      end
   end

   always_comb begin
      w_rd1 = '0;
      if (rs1_i == 5'd0) begin
         w_rd1 = '0;
      end else if (w_wen && (rs1_i == wr_wb_i)) begin
         w_rd1 = wd_wb_i;
      end else begin
         w_rd1 = r_regs[rs1_i];
      end
   end

   always_comb begin
      w_rd2 = '0;
      if (rs2_i == 5'd0) begin
         w_rd2 = '0;
      end else if (w_wen && (rs2_i == wr_wb_i)) begin
         w_rd2 = wd_wb_i;
      end else begin
         w_rd2 = r_regs[rs2_i];
      end
   end

   assign rd1_o          = w_rd1;
   assign rd2_o          = w_rd2;
   assign instret_o      = r_instret;
   assign commit_valid_o = r_cvalid;
   assign commit_pc_o    = r_cpc;
   assign commit_rd_o    = r_crd;
   assign commit_we_o    = r_cwe;
   assign commit_wd_o    = r_cwd;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed cases, then random
// traffic against an array/counter reference model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_wb_i;
   logic        instr_valid_wb_i;
   logic        rf_we_wb_i;
   logic [4:0]  wr_wb_i;
   logic [31:0] wd_wb_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [31:0] rd1_o;
   logic [31:0] rd2_o;
   logic [63:0] instret_o;
   logic        commit_valid_o;
   logic [31:0] commit_pc_o;
   logic [4:0]  commit_rd_o;
   logic        commit_we_o;
   logic [31:0] commit_wd_o;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .pc_wb_i          (pc_wb_i),
      .instr_valid_wb_i (instr_valid_wb_i),
      .rf_we_wb_i       (rf_we_wb_i),
      .wr_wb_i          (wr_wb_i),
      .wd_wb_i          (wd_wb_i),
      .rs1_i            (rs1_i),
      .rs2_i            (rs2_i),
      .rd1_o            (rd1_o),
      .rd2_o            (rd2_o),
      .instret_o        (instret_o),
      .commit_valid_o   (commit_valid_o),
      .commit_pc_o      (commit_pc_o),
      .commit_rd_o      (commit_rd_o),
      .commit_we_o      (commit_we_o),
      .commit_wd_o      (commit_wd_o)
   );

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] wd;
      logic [63:0] ins;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_regs [32];
   logic [63:0] m_ins;
   int          n_vec = 0;
   int          n_bad = 0;

   function automatic void chk(input string nm,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endfunction

   // Architectural read: x0 is zero, a same-cycle write wins.
   function automatic logic [31:0] ref_rd(input logic [4:0] s,
                                          input logic wen,
                                          input logic [4:0] a,
                                          input logic [31:0] d);
      if (s == 0) return 32'd0;
      if (wen && s == a) return d;
      return m_regs[s];
   endfunction

   task automatic step(input logic r, input logic v,
                       input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] p,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input bit chk_rd);
      logic wen;
      exp_t e;
      rst = r;
      instr_valid_wb_i = v;
      rf_we_wb_i = w;
      wr_wb_i = a;
      wd_wb_i = d;
      pc_wb_i = p;
      rs1_i = s1;
      rs2_i = s2;
      wen = v && w && (a != 0);
      #1;
      if (chk_rd) begin
         chk("rd1", 64'(rd1_o), 64'(ref_rd(s1, wen, a, d)));
         chk("rd2", 64'(rd2_o), 64'(ref_rd(s2, wen, a, d)));
      end
      if (r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_ins = 64'd0;
         e = '{v: 1'b0, pc: 32'd0, rd: 5'd0, we: 1'b0,
               wd: 32'd0, ins: 64'd0};
      end else begin
         if (wen) m_regs[a] = d;
         if (v) m_ins = m_ins + 64'd1;
         e = '{v: v, pc: p, rd: a, we: wen,
               wd: wen ? d : 32'd0, ins: m_ins};
      end
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one expected record per retired clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("commit_valid", 64'(commit_valid_o), 64'(e.v));
            chk("instret", instret_o, e.ins);
            if (e.v) begin
               chk("commit_pc", 64'(commit_pc_o), 64'(e.pc));
               chk("commit_rd", 64'(commit_rd_o), 64'(e.rd));
               chk("commit_we", 64'(commit_we_o), 64'(e.we));
               chk("commit_wd", 64'(commit_wd_o), 64'(e.wd));
            end
         end
      end
   end

   initial begin
      int guard;
      logic [4:0] a;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ins = 64'd0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset state
      step(0, 0, 0, 0, 0, 0, 5, 31, 1);
      // bypass then array read of x3
      step(0, 1, 1, 3, 32'hDEADBEEF, 32'h100, 3, 0, 1);
      step(0, 0, 0, 0, 0, 0, 3, 3, 1);
      // x0 write is dropped but still retires
      step(0, 1, 1, 0, 32'h1234, 32'h104, 0, 0, 1);
      // bubble with write enable
      step(0, 0, 1, 7, 32'h55, 32'h108, 7, 0, 1);
      step(0, 0, 0, 0, 0, 0, 7, 3, 1);
      // 10 valid / 5 bubbles, then counter wrap
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) begin
         step(0, (i % 3) != 2, 1'($urandom), 5'($urandom),
              $urandom, 32'h200 + 32'(i * 4), 0, 0, 1);
      end
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.r_instret;
      m_ins = 64'hFFFF_FFFF_FFFF_FFFF;
      step(0, 1, 0, 0, 0, 32'h300, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      // reset beats a simultaneous write; bypass stays live
      step(0, 1, 1, 9, 32'h77, 32'h400, 9, 0, 1);
      step(1, 1, 1, 9, 32'hA5, 32'h404, 9, 0, 1);
      step(0, 0, 0, 0, 0, 0, 9, 9, 1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         a = 5'($urandom);
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0),
              a, $urandom, $urandom,
              ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
              ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
              1);
      end
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d records left expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
